// File: rtl/pce_pkg.sv
// pce_pkg: shared FSM state encoding and default memory-map constants for pattern_count_engine
package pce_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_PAT,
    RD_MSG,
    DRAIN,
    WR_CTB,
    WR_CTO,
    WR_CTS,
    DONE
  } pce_state_t;
  localparam int DEF_MSG_BYTES = 32;
  localparam int DEF_PAT_ADDR  = 32;
  localparam int DEF_OUT_BASE  = 33;
endpackage

// File: rtl/pce_window_match.sv
// pce_window_match: counts 5-bit pattern hits in the 12-bit string {prev nibble, cur byte}
//   str       in  12  {prev[3:0], cur[7:0]}, MSB-first
//   pat       in  5   pattern
//   first     in  1   cur is byte 0 (no crossing windows)
//   in_cnt    out 3   hits fully inside cur
//   cross_cnt out 4   hits starting in prev and ending in cur
//   any       out 1   in_cnt nonzero
module pce_window_match (
  input  logic [11:0] str,
  input  logic [4:0]  pat,
  input  logic        first,
  output logic [2:0]  in_cnt,
  output logic [3:0]  cross_cnt,
  output logic        any
);
  always_comb begin
    in_cnt    = '0;
    cross_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      in_cnt    = in_cnt + 3'(str[i +: 5] == pat);
      cross_cnt = cross_cnt + 4'(!first && str[i + 4 +: 5] == pat);
    end
    any = in_cnt != '0;
  end
endmodule

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: reads pattern + message from data memory, writes ctb/cto/cts match counts
//   clk        in  1   system clock
//   reset      in  1   synchronous active-low reset
//   req        in  1   start pulse (accepted in IDLE/DONE only)
//   done       out 1   job complete, held until next accepted req
//   mem_raddr  out AW  registered read address
//   mem_rdata  in  8   read data, valid one cycle after mem_raddr
//   mem_wen    out 1   write strobe
//   mem_waddr  out AW  write address
//   mem_wdata  out 8   write data
module pattern_count_engine
  import pce_pkg::*;
#(
  parameter int MSG_BYTES = DEF_MSG_BYTES,
  parameter int PAT_ADDR  = DEF_PAT_ADDR,
  parameter int OUT_BASE  = DEF_OUT_BASE,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_raddr,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata
);
  pce_state_t state, state_n;
  logic [AW-1:0] raddr, raddr_n;
  logic [4:0] pat;
  logic [3:0] prev;
  logic [7:0] ctb, cto, cts;
  logic [2:0] in_cnt;
  logic [3:0] cross_cnt;
  logic any, start, consume, first, grab_pat;
  logic [1:0] wsel;
  pce_window_match u_match (
    .str      ({prev, mem_rdata}),
    .pat      (pat),
    .first    (first),
    .in_cnt   (in_cnt),
    .cross_cnt(cross_cnt),
    .any      (any)
  );
  // Data for address a arrives while address a+1 is being issued, so in RD_MSG
  // the pattern byte is on rdata when raddr==0 and message byte raddr-1 otherwise.
  always_comb begin
    start    = (state == IDLE || state == DONE) && req;
    grab_pat = state == RD_MSG && raddr == '0;
    consume  = (state == RD_MSG && raddr != '0) || state == DRAIN;
    first    = state == RD_MSG && raddr == AW'(1);
    state_n  = state;
    raddr_n  = raddr;
    case (state)
      IDLE, DONE: if (req) begin
        state_n = RD_PAT;
        raddr_n = AW'(PAT_ADDR);
      end
      RD_PAT: begin
        state_n = RD_MSG;
        raddr_n = '0;
      end
      RD_MSG: if (raddr == AW'(MSG_BYTES - 1)) state_n = DRAIN;
              else raddr_n = raddr + AW'(1);
      DRAIN:  state_n = WR_CTB;
      WR_CTB: state_n = WR_CTO;
      WR_CTO: state_n = WR_CTS;
      WR_CTS: state_n = DONE;
      default: state_n = IDLE;
    endcase
    wsel      = state == WR_CTO ? 2'd1 : state == WR_CTS ? 2'd2 : 2'd0;
    mem_wen   = state == WR_CTB || state == WR_CTO || state == WR_CTS;
    mem_waddr = mem_wen ? AW'(OUT_BASE) + AW'(wsel) : '0;
    mem_wdata = !mem_wen ? 8'd0 : wsel == 2'd0 ? ctb : wsel == 2'd1 ? cto : cts;
  end
  assign mem_raddr = raddr;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      raddr <= '0;
      pat   <= '0;
      prev  <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      raddr <= raddr_n;
      done  <= state == DONE && !req;
      if (start) begin
        ctb  <= '0;
        cto  <= '0;
        cts  <= '0;
        prev <= '0;
      end
      if (grab_pat) pat <= mem_rdata[7:3];
      if (consume) begin
        prev <= mem_rdata[3:0];
        ctb  <= ctb + 8'(in_cnt);
        cto  <= cto + 8'(any);
        cts  <= cts + 8'(in_cnt) + 8'(cross_cnt);
      end
    end
  end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: directed table + random jobs against a bit-string reference model
module tb_pattern_count_engine;
  logic clk = 1'b0, reset = 1'b0, req = 1'b0;
  logic done, mem_wen;
  logic [7:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  int errors = 0, checks = 0, wr_count = 0;
  always #5 clk = ~clk;
  pattern_count_engine dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .done     (done),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .mem_wen  (mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );
  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr];
    if (mem_wen) begin
      mem[mem_waddr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Treat the message as one 256-bit MSB-first string and slide a window over it.
  task automatic model(input logic [4:0] p, output int eb, output int eo, output int es);
    logic [255:0] bits;
    int pb [32];
    for (int k = 0; k < 32; k++) begin
      bits[255 - 8 * k -: 8] = mem[k];
      pb[k] = 0;
    end
    eb = 0; eo = 0; es = 0;
    for (int e = 4; e < 256; e++) begin
      if (bits[255 - e +: 5] == p) begin
        es++;
        if (e % 8 >= 4) pb[e / 8]++;
      end
    end
    for (int k = 0; k < 32; k++) begin
      eb += pb[k];
      if (pb[k] != 0) eo++;
    end
  endtask
  task automatic run_job(input string tag, input int hold, input int pulse_at);
    int n, eb, eo, es, wr0;
    logic from_done;
    model(mem[32][7:3], eb, eo, es);
    @(negedge clk);
    from_done = done;
    wr0 = wr_count;
    req = 1'b1;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    if (from_done) check({tag, "_done_drop"}, int'(done), 0);
    while (!done && n < 100) begin
      req = (n + 1 < hold) || (n + 1 == pulse_at);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    check({tag, "_latency"}, n, 38);
    check({tag, "_writes"}, wr_count - wr0, 3);
    check({tag, "_ctb"}, int'(mem[33]), eb);
    check({tag, "_cto"}, int'(mem[34]), eo);
    check({tag, "_cts"}, int'(mem[35]), es);
  endtask
  typedef struct {
    logic [7:0] fill, b0, b1, patb;
    int ctb, cto, cts;
  } vec_t;
  initial begin
    vec_t v [5];
    int bad, wr0;
    v[0] = '{8'h55, 8'h55, 8'h55, 8'hA8, 64, 32, 126};
    v[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 128, 32, 252};
    v[2] = '{8'h00, 8'h00, 8'h00, 8'hF8, 0, 0, 0};
    v[3] = '{8'h00, 8'h03, 8'hE0, 8'hF8, 0, 0, 1};
    v[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFB, 128, 32, 252};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", int'(done), 0);
    check("rst_wen", int'(mem_wen), 0);
    check("rst_raddr", int'(mem_raddr), 0);
    check("rst_waddr", int'(mem_waddr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    reset = 1'b1;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 32; k++) mem[k] = v[t].fill;
      mem[0] = v[t].b0;
      mem[1] = v[t].b1;
      mem[32] = v[t].patb;
      run_job($sformatf("vec%0d", t), 1, -1);
      check($sformatf("vec%0d_tbl_ctb", t), int'(mem[33]), v[t].ctb);
      check($sformatf("vec%0d_tbl_cto", t), int'(mem[34]), v[t].cto);
      check($sformatf("vec%0d_tbl_cts", t), int'(mem[35]), v[t].cts);
    end
    for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
    mem[32] = 8'($urandom);
    run_job("hold5", 5, -1);
    run_job("pulse5", 1, 5);
    mem[33] = 8'hAA; mem[34] = 8'hAA; mem[35] = 8'hAA;
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("abort_done", int'(done), 0);
    check("abort_raddr", int'(mem_raddr), 0);
    wr0 = wr_count;
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (mem_raddr != 8'd0 || done || mem_wen) bad++;
    end
    check("abort_idle", bad, 0);
    check("abort_writes", wr_count - wr0, 0);
    check("abort_m33", int'(mem[33]), 8'hAA);
    check("abort_m34", int'(mem[34]), 8'hAA);
    check("abort_m35", int'(mem[35]), 8'hAA);
    reset = 1'b0;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    req = 1'b0;
    check("rst_req_raddr", int'(mem_raddr), 0);
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (done || mem_wen || mem_raddr != 8'd0) bad++;
    end
    check("rst_req_idle", bad, 0);
    for (int j = 0; j < 200; j++) begin
      for (int k = 0; k < 32; k++) mem[k] = 8'($urandom);
      mem[32] = 8'($urandom);
      run_job($sformatf("rand%0d", j), 1, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
